// File: rtl/axi4_rab_pkg.sv
// axi4_rab_pkg: shared R-channel field offsets and packed-width helper
package axi4_rab_pkg;
  localparam int RESP_LSB = 0;
  localparam int LAST_BIT = 2;
  localparam int DATA_LSB = 3;
  function automatic int r_width(input int id_w, input int user_w, input int data_w);
    return user_w + id_w + data_w + 3;
  endfunction
endpackage

// File: rtl/axi_rch_fifo.sv
// axi_rch_fifo: generic ready/valid circular register FIFO with occupancy count
module axi_rch_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CW-1:0]         count,
  output logic                  full,
  output logic                  empty
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic push, pop;
  always_comb begin
    full = count == CW'(DEPTH);
    empty = count == '0;
    in_ready = !full;
    out_valid = !empty;
    out_data = mem[rd_ptr];
    push = in_valid && in_ready;
    pop = out_valid && out_ready;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= (push && !pop) ? count + CW'(1) : (pop && !push) ? count - CW'(1) : count;
    end
  end
endmodule

// File: rtl/axi4_rch_buffer.sv
// axi4_rch_buffer: in-order AXI4 R-channel buffer packing beats into a register FIFO
module axi4_rch_buffer
  import axi4_rab_pkg::*;
#(
  parameter int C_AXI_ID_WIDTH = 4,
  parameter int C_AXI_USER_WIDTH = 4,
  parameter int C_AXI_DATA_WIDTH = 64,
  parameter int C_BUFFER_DEPTH = 4
) (
  input  logic                               axi4_aclk,
  input  logic                               axi4_arstn,
  input  logic [C_AXI_ID_WIDTH-1:0]          m_axi4_rid,
  input  logic [C_AXI_DATA_WIDTH-1:0]        m_axi4_rdata,
  input  logic [1:0]                         m_axi4_rresp,
  input  logic                               m_axi4_rlast,
  input  logic [C_AXI_USER_WIDTH-1:0]        m_axi4_ruser,
  input  logic                               m_axi4_rvalid,
  output logic                               m_axi4_rready,
  output logic [C_AXI_ID_WIDTH-1:0]          s_axi4_rid,
  output logic [C_AXI_DATA_WIDTH-1:0]        s_axi4_rdata,
  output logic [1:0]                         s_axi4_rresp,
  output logic                               s_axi4_rlast,
  output logic [C_AXI_USER_WIDTH-1:0]        s_axi4_ruser,
  output logic                               s_axi4_rvalid,
  input  logic                               s_axi4_rready,
  output logic [$clog2(C_BUFFER_DEPTH):0]    buf_count
);
  localparam int W = r_width(C_AXI_ID_WIDTH, C_AXI_USER_WIDTH, C_AXI_DATA_WIDTH);
  localparam int ID_LSB = DATA_LSB + C_AXI_DATA_WIDTH;
  localparam int USER_LSB = ID_LSB + C_AXI_ID_WIDTH;
  logic [W-1:0] in_entry, out_entry;
  logic in_ready, full, empty;
  assign in_entry = {m_axi4_ruser, m_axi4_rid, m_axi4_rdata, m_axi4_rlast, m_axi4_rresp};
  axi_rch_fifo #(.DATA_WIDTH(W), .DEPTH(C_BUFFER_DEPTH)) u_fifo (
    .clk(axi4_aclk),
    .rst(!axi4_arstn),
    .in_data(in_entry),
    .in_valid(m_axi4_rvalid),
    .in_ready(in_ready),
    .out_data(out_entry),
    .out_valid(s_axi4_rvalid),
    .out_ready(s_axi4_rready),
    .count(buf_count),
    .full(full),
    .empty(empty)
  );
  always_comb begin
    m_axi4_rready = in_ready && axi4_arstn;
    s_axi4_rresp = out_entry[RESP_LSB +: 2];
    s_axi4_rlast = out_entry[LAST_BIT];
    s_axi4_rdata = out_entry[DATA_LSB +: C_AXI_DATA_WIDTH];
    s_axi4_rid = out_entry[ID_LSB +: C_AXI_ID_WIDTH];
    s_axi4_ruser = out_entry[USER_LSB +: C_AXI_USER_WIDTH];
  end
endmodule

// File: tb/tb_axi4_rch_buffer.sv
// tb_axi4_rch_buffer: directed self-checking bench for axi4_rch_buffer
module tb_axi4_rch_buffer;
  logic clk = 0;
  logic rst_n = 0;
  logic [3:0] m_rid = '0, s_rid, m_ruser = '0, s_ruser;
  logic [63:0] m_rdata = '0, s_rdata;
  logic [1:0] m_rresp = '0, s_rresp;
  logic m_rlast = 0, m_rvalid = 0, m_rready, s_rlast, s_rvalid, s_rready = 0;
  logic [2:0] buf_count;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  axi4_rch_buffer dut (
    .axi4_aclk(clk),
    .axi4_arstn(rst_n),
    .m_axi4_rid(m_rid),
    .m_axi4_rdata(m_rdata),
    .m_axi4_rresp(m_rresp),
    .m_axi4_rlast(m_rlast),
    .m_axi4_ruser(m_ruser),
    .m_axi4_rvalid(m_rvalid),
    .m_axi4_rready(m_rready),
    .s_axi4_rid(s_rid),
    .s_axi4_rdata(s_rdata),
    .s_axi4_rresp(s_rresp),
    .s_axi4_rlast(s_rlast),
    .s_axi4_ruser(s_ruser),
    .s_axi4_rvalid(s_rvalid),
    .s_axi4_rready(s_rready),
    .buf_count(buf_count)
  );
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [63:0] d, input logic l);
    m_rvalid = v;
    m_rdata = d;
    m_rlast = l;
  endtask
  logic [74:0] prev_pl, exp_pl;
  logic [3:0] usr [10];
  bit prev_stall;
  int n_sent, n_rcv, off;
  bit acc;
  initial begin
    tick;
    tick;
    chk("rst_rvalid", s_rvalid, 0);
    chk("rst_rready", m_rready, 0);
    chk("rst_count", buf_count, 0);
    chk("rst_rdata", s_rdata, 0);
    rst_n = 1;
    #1;
    chk("rel_rready", m_rready, 1);
    // reset mid-burst
    for (int i = 0; i < 3; i++) begin
      drive(1, 64'hAA00 + 64'(i), 0);
      m_rid = 4'h3;
      tick;
    end
    drive(0, 0, 0);
    m_rid = 0;
    chk("mid_count", buf_count, 3);
    chk("mid_rdata", s_rdata, 64'hAA00);
    rst_n = 0;
    tick;
    chk("mid_rst_rvalid", s_rvalid, 0);
    chk("mid_rst_count", buf_count, 0);
    chk("mid_rst_rdata", s_rdata, 0);
    chk("mid_rst_rid", s_rid, 0);
    rst_n = 1;
    #1;
    chk("mid_rel_rready", m_rready, 1);
    tick;
    // fill/stall with 6 beats offered
    s_rready = 0;
    off = 0;
    for (int c = 0; c < 6; c++) begin
      drive(1, 64'h10 + 64'(off), off == 5);
      #1;
      acc = m_rready;
      tick;
      if (acc) off++;
    end
    drive(1, 64'h10 + 64'(off), off == 5);
    #1;
    chk("fill_accepted", off, 4);
    chk("fill_rready", m_rready, 0);
    chk("fill_count", buf_count, 4);
    chk("fill_head", s_rdata, 64'h10);
    s_rready = 1;
    for (int j = 0; j < 6; j++) begin
      #1;
      chk("drain_valid", s_rvalid, 1);
      chk("drain_data", s_rdata, 64'h10 + 64'(j));
      chk("drain_last", s_rlast, j == 5);
      acc = m_rvalid && m_rready;
      tick;
      if (acc) off++;
      if (off < 6) drive(1, 64'h10 + 64'(off), off == 5);
      else drive(0, 0, 0);
    end
    #1;
    chk("drain_empty", s_rvalid, 0);
    chk("drain_count", buf_count, 0);
    // streaming 16 beats
    m_rid = 4'h5;
    m_rresp = 2'b00;
    for (int k = 0; k <= 16; k++) begin
      if (k < 16) drive(1, 64'h100 + 64'(k), k == 15);
      else drive(0, 0, 0);
      #1;
      if (k == 0) chk("stream_first_empty", s_rvalid, 0);
      else begin
        chk("stream_valid", s_rvalid, 1);
        chk("stream_data", s_rdata, 64'h100 + 64'(k - 1));
        chk("stream_last", s_rlast, k == 16);
        chk("stream_rid", s_rid, 4'h5);
        chk("stream_count", buf_count, 1);
      end
      tick;
    end
    chk("stream_end_count", buf_count, 0);
    m_rid = 0;
    // simultaneous push/pop at full
    s_rready = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1, 64'h20 + 64'(i), 0);
      tick;
    end
    drive(1, 64'h24, 0);
    s_rready = 1;
    #1;
    chk("full_rready", m_rready, 0);
    chk("full_count", buf_count, 4);
    tick;
    chk("full_pop_count", buf_count, 3);
    chk("full_pop_rready", m_rready, 1);
    chk("full_pop_head", s_rdata, 64'h21);
    tick;
    drive(0, 0, 0);
    chk("both_count", buf_count, 3);
    for (int j = 0; j < 3; j++) begin
      chk("full_drain", s_rdata, 64'h22 + 64'(j));
      tick;
    end
    chk("full_drain_count", buf_count, 0);
    // wrap-around with random backpressure
    for (int k = 0; k < 10; k++) usr[k] = 4'($urandom_range(0, 15));
    m_rresp = 2'b10;
    n_sent = 0;
    n_rcv = 0;
    prev_stall = 0;
    prev_pl = '0;
    for (int c = 0; c < 300 && n_rcv < 10; c++) begin
      s_rready = 1'($urandom_range(0, 1));
      if (n_sent < 10) begin
        drive(1, 64'hC0 + 64'(n_sent), 1);
        m_rid = n_sent[3:0];
        m_ruser = usr[n_sent];
      end else drive(0, 0, 0);
      #1;
      if (prev_stall) chk("wrap_stable", {s_ruser, s_rid, s_rdata, s_rlast, s_rresp}, prev_pl);
      if (s_rvalid && s_rready) begin
        exp_pl = {usr[n_rcv], n_rcv[3:0], 64'hC0 + 64'(n_rcv), 1'b1, 2'b10};
        chk("wrap_beat", {s_ruser, s_rid, s_rdata, s_rlast, s_rresp}, exp_pl);
        n_rcv++;
      end
      prev_stall = s_rvalid && !s_rready;
      prev_pl = {s_ruser, s_rid, s_rdata, s_rlast, s_rresp};
      acc = m_rvalid && m_rready;
      tick;
      if (acc) n_sent++;
    end
    drive(0, 0, 0);
    chk("wrap_received", n_rcv, 10);
    #1;
    chk("wrap_end_count", buf_count, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
